// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch-address sequencer: FSM states, defaults and the
// redirect-source index type.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } pc_state_e;

  localparam int INC_BYTES_DEF = 4;
  localparam int NUM_REDIR_DEF = 3;

  // Wide enough for up to 16 redirect sources.
  localparam int REDIR_IDX_W = 4;
  typedef logic [REDIR_IDX_W-1:0] redir_idx_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle: address/valid/ready handshake toward imem, redirect
// requests from EX/MEM, and the flush/misalign pulses.
interface pc_sequencer_if #(
  parameter int XLEN      = 32,
  parameter int NUM_REDIR = 3
);
  logic [XLEN-1:0]           pc;
  logic                      pc_valid;
  logic                      fetch_ready;
  logic                      flush;
  logic                      misalign_err;
  logic [NUM_REDIR-1:0]      redir_valid;
  logic [NUM_REDIR*XLEN-1:0] redir_target;

  modport master (
    output pc, pc_valid, flush, misalign_err,
    input  fetch_ready, redir_valid, redir_target
  );

  modport slave (
    input  pc, pc_valid, flush, misalign_err,
    output fetch_ready, redir_valid, redir_target
  );
endinterface

// File: rtl/pc_sequencer_redir_prio_sel.sv
// Fixed-priority redirect selector: the lowest-index valid source wins and its
// target is muxed out.
module redir_prio_sel
  import pc_seq_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REDIR = 3
) (
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target_i,
  output logic                      sel_valid_o,
  output logic [XLEN-1:0]           sel_target_o
);

  redir_idx_t sel_idx;

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    sel_valid_o = 1'b0;
    sel_idx     = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid_i[i]) begin
        sel_valid_o = 1'b1;
        sel_idx     = redir_idx_t'(i);
      end
    end
  end

  assign sel_target_o = redir_target_i[int'(sel_idx)*XLEN +: XLEN];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator at the head of IF: prioritised redirects, handshake
// hold, multi-cycle stalls and load-use holds. All outputs are registered.
//
//   state    | meaning
//   ST_BOOT  | out of reset, no request in flight (pc_valid=0)
//   ST_RUN   | issuing fetches, pc advances on acceptance
//   ST_STALL | pc held while the stall down-counter drains
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0,
  parameter int              INC_BYTES = INC_BYTES_DEF,
  parameter int              NUM_REDIR = NUM_REDIR_DEF,
  parameter int              STALL_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_use_stall_flag_i,
  input  logic               stall_req_i,
  input  logic [STALL_W-1:0] stall_cycles_i,
  pc_sequencer_if.master     fetch_if
);

  pc_state_e        state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pend_vld_q, pend_vld_d;
  logic [XLEN-1:0]  pend_tgt_q, pend_tgt_d;
  logic             flush_q, flush_d;
  logic             mis_q, mis_d;

  logic             sel_valid;
  logic [XLEN-1:0]  sel_target;
  logic             hold;
  logic             redir_go;
  logic [XLEN-1:0]  redir_tgt;
  logic [STALL_W-1:0] stall_len;
  logic [XLEN-1:0]  pc_inc;

  redir_prio_sel #(.XLEN(XLEN), .NUM_REDIR(NUM_REDIR)) u_sel (
    .redir_valid_i  (fetch_if.redir_valid),
    .redir_target_i (fetch_if.redir_target),
    .sel_valid_o    (sel_valid),
    .sel_target_o   (sel_target)
  );

  assign hold      = (state_q != ST_BOOT) && !fetch_if.fetch_ready;
  // A fresh redirect is newer than anything parked during a hold.
  assign redir_go  = sel_valid || pend_vld_q;
  assign redir_tgt = sel_valid ? sel_target : pend_tgt_q;
  assign stall_len = (stall_cycles_i == '0) ? STALL_W'(1) : stall_cycles_i;
  assign pc_inc    = pc_q + XLEN'(INC_BYTES);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    flush_d    = 1'b0;
    mis_d      = 1'b0;

    if (hold) begin
      if (sel_valid) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = sel_target;
      end
    end else if (redir_go) begin
      pc_d       = {redir_tgt[XLEN-1:2], 2'b00};
      flush_d    = 1'b1;
      mis_d      = |redir_tgt[1:0];
      state_d    = ST_RUN;
      cnt_d      = '0;
      pend_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (stall_req_i) begin
            state_d = ST_STALL;
            cnt_d   = stall_len - STALL_W'(1);
          end else if (!load_use_stall_flag_i) begin
            pc_d = pc_inc;
          end
        end
        ST_STALL: begin
          // cnt_q counts remaining hold edges; a new request may only extend it.
          if (stall_req_i) begin
            cnt_d = ((cnt_q > stall_len) ? cnt_q : stall_len) - STALL_W'(1);
          end else if (cnt_q == '0) begin
            state_d = ST_RUN;
            pc_d    = pc_inc;
          end else begin
            cnt_d = cnt_q - STALL_W'(1);
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      cnt_q      <= '0;
      pc_q       <= BOOT_ADDR;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
    end
  end

  assign fetch_if.pc           = pc_q;
  assign fetch_if.pc_valid     = (state_q != ST_BOOT);
  assign fetch_if.flush        = flush_q;
  assign fetch_if.misalign_err = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, stalls, redirect priority, redirect
// under handshake hold, stall cancellation, async reset and address wrap.
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       load_use;
  logic       stall_req;
  logic [2:0] stall_cycles;

  int n_checks = 0;
  int n_err    = 0;

  pc_sequencer_if #(.XLEN(32), .NUM_REDIR(3)) bus ();

  pc_sequencer #(
    .XLEN(32), .BOOT_ADDR(32'h0000_0000), .INC_BYTES(4), .NUM_REDIR(3), .STALL_W(3)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .load_use_stall_flag_i (load_use),
    .stall_req_i           (stall_req),
    .stall_cycles_i        (stall_cycles),
    .fetch_if              (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_redir(input logic [2:0] v, input logic [31:0] t0,
                           input logic [31:0] t1, input logic [31:0] t2);
    bus.redir_valid  = v;
    bus.redir_target = {t2, t1, t0};
  endtask

  initial begin
    rst_n = 1'b0;
    load_use = 1'b0;
    stall_req = 1'b0;
    stall_cycles = 3'd0;
    bus.fetch_ready = 1'b1;
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);

    // T1 reset / boot
    #1;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_valid", {31'b0, bus.pc_valid}, 32'h0);
    check("rst_flush", {31'b0, bus.flush}, 32'h0);
    check("rst_mis", {31'b0, bus.misalign_err}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("boot_valid0", {31'b0, bus.pc_valid}, 32'h0);
    tick();
    check("boot_valid1", {31'b0, bus.pc_valid}, 32'h1);
    check("boot_pc0", bus.pc, 32'h0);
    tick();
    check("boot_pc4", bus.pc, 32'h4);
    tick();
    check("boot_pc8", bus.pc, 32'h8);

    // T2 multi-cycle stall of 3, then stall of 0 (treated as 1)
    stall_req = 1'b1; stall_cycles = 3'd3;
    tick();
    stall_req = 1'b0;
    check("stall3_h1", bus.pc, 32'h8);
    tick();
    check("stall3_h2", bus.pc, 32'h8);
    tick();
    check("stall3_h3", bus.pc, 32'h8);
    tick();
    check("stall3_end", bus.pc, 32'hC);
    stall_req = 1'b1; stall_cycles = 3'd0;
    tick();
    stall_req = 1'b0;
    check("stall0_h1", bus.pc, 32'hC);
    tick();
    check("stall0_end", bus.pc, 32'h10);

    // load-use holds one cycle only
    load_use = 1'b1;
    tick();
    load_use = 1'b0;
    check("lu_hold", bus.pc, 32'h10);
    tick();
    check("lu_end", bus.pc, 32'h14);

    // T3 priority and misalign
    set_redir(3'b110, 32'h0, 32'h100, 32'h200);
    tick();
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);
    check("prio_pc", bus.pc, 32'h100);
    check("prio_flush", {31'b0, bus.flush}, 32'h1);
    check("prio_mis", {31'b0, bus.misalign_err}, 32'h0);
    tick();
    check("prio_inc", bus.pc, 32'h104);
    check("prio_flush_end", {31'b0, bus.flush}, 32'h0);
    set_redir(3'b001, 32'h42, 32'h0, 32'h0);
    tick();
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);
    check("mis_pc", bus.pc, 32'h40);
    check("mis_flush", {31'b0, bus.flush}, 32'h1);
    check("mis_err", {31'b0, bus.misalign_err}, 32'h1);
    tick();
    check("mis_inc", bus.pc, 32'h44);
    check("mis_err_end", {31'b0, bus.misalign_err}, 32'h0);

    // T4 redirects under handshake hold; the later one wins
    set_redir(3'b001, 32'h20, 32'h0, 32'h0);
    tick();
    check("t4_pc20", bus.pc, 32'h20);
    bus.fetch_ready = 1'b0;
    set_redir(3'b100, 32'h0, 32'h0, 32'h300);
    tick();
    check("t4_hold1", bus.pc, 32'h20);
    check("t4_hold1_flush", {31'b0, bus.flush}, 32'h0);
    set_redir(3'b010, 32'h0, 32'h400, 32'h0);
    tick();
    check("t4_hold2", bus.pc, 32'h20);
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);
    bus.fetch_ready = 1'b1;
    tick();
    check("t4_apply", bus.pc, 32'h400);
    check("t4_flush", {31'b0, bus.flush}, 32'h1);
    tick();
    check("t4_inc", bus.pc, 32'h404);
    check("t4_flush_end", {31'b0, bus.flush}, 32'h0);

    // T5 redirect cancels an ongoing stall
    stall_req = 1'b1; stall_cycles = 3'd6;
    tick();
    stall_req = 1'b0;
    check("t5_hold1", bus.pc, 32'h404);
    tick();
    check("t5_hold2", bus.pc, 32'h404);
    set_redir(3'b001, 32'h80, 32'h0, 32'h0);
    tick();
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);
    check("t5_redir", bus.pc, 32'h80);
    check("t5_flush", {31'b0, bus.flush}, 32'h1);
    tick();
    check("t5_run", bus.pc, 32'h84);

    // async reset mid-stall
    stall_req = 1'b1; stall_cycles = 3'd7;
    tick();
    stall_req = 1'b0;
    check("t5b_hold", bus.pc, 32'h84);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", bus.pc, 32'h0);
    check("arst_valid", {31'b0, bus.pc_valid}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("arst_boot", {31'b0, bus.pc_valid}, 32'h0);
    tick();
    check("arst_run_pc", bus.pc, 32'h0);
    check("arst_run_valid", {31'b0, bus.pc_valid}, 32'h1);
    tick();
    check("arst_nostall", bus.pc, 32'h4);

    // T6 wrap from the top of the address space
    set_redir(3'b010, 32'h0, 32'hFFFF_FFFC, 32'h0);
    tick();
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);
    check("wrap_top", bus.pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_flush", {31'b0, bus.flush}, 32'h0);
    check("wrap_mis", {31'b0, bus.misalign_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
